line_clear_engine: RTL
======================

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 COLS, default 4: board width in cells; legal range 2..16.
REQ-002 ROWS, default 8: board height in rows; legal range 2..32.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  request to process board_in; sampled only in IDLE.
REQ-006 board_in  in  COLS*ROWS  board snapshot; row r = bits [r*COLS +: COLS]; row 0 = bottom.
REQ-007 busy  out  1  high in SCAN, SHIFT and DONE.
REQ-008 done  out  1  one-cycle pulse when the result is valid.
REQ-009 board_out  out  COLS*ROWS  collapsed board; same row layout as board_in.
REQ-010 lines_cleared  out  $clog2(ROWS+1)  number of full rows removed in the last job.
REQ-011 score  out  16  running score; present only with SCORE_EN (see Configuration).

Function
REQ-012 The block SHALL implement states IDLE, SCAN, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load board_in into the internal board, clear the count and set row index idx=0, then enter SCAN.
REQ-014 In SCAN, the block SHALL test row idx; a row is full when all COLS bits are 1.
REQ-015 In SCAN, if the row is full, the block SHALL increment the count and enter SHIFT.
REQ-016 In SCAN, if the row is not full and idx<ROWS-1, the block SHALL set idx=idx+1 and stay in SCAN.
REQ-017 In SCAN, if the row is not full and idx=ROWS-1, the block SHALL enter DONE.
REQ-018 SHIFT SHALL take one cycle: rows idx..ROWS-2 take the contents of the row above, row ROWS-1 becomes all zero, rows below idx are unchanged, idx is unchanged, and the next state is SCAN, so the same row is re-tested.
REQ-019 In DONE, the block SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-020 board_out and lines_cleared SHALL be driven from registers, remain stable from DONE until the next accepted start, and never show intermediate values outside SCAN and SHIFT.
REQ-021 start in any state other than IDLE SHALL be ignored; it is not queued.
REQ-022 Latency: with k full rows, done SHALL assert (ROWS+2k+1) cycles after the accepting edge. With no clears and ROWS=8, done is high in cycle 9.
REQ-023 Counter widths SHALL hold ROWS without overflow; an all-ones board clears ROWS rows and returns an all-zero board.
REQ-024 A full top row SHALL be replaced by zeros in SHIFT; the re-test then fails and the block enters DONE.

Reset
REQ-025 While rst=1, the block SHALL force the IDLE state, idx=0, busy=0, done=0, board_out=0, lines_cleared=0 and score=0.
REQ-026 rst asserted mid-job SHALL abort the job at the next edge; no done pulse SHALL be issued for the aborted job.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro LINE_CLEAR_SCORE_EN: when defined, the score port and a 16-bit accumulator SHALL exist.
REQ-029 With LINE_CLEAR_SCORE_EN, on entry to DONE the block SHALL add 0 for 0 lines, 1 for 1 line, 3 for 2 lines, 5 for 3 lines and 8 for 4 or more lines.
REQ-030 The score addition SHALL saturate at 0xFFFF, and score SHALL be cleared only by rst.
REQ-031 Without LINE_CLEAR_SCORE_EN, the score port and its logic SHALL be absent; all other behaviour is identical.

Verification (COLS=4, ROWS=8)
REQ-032 board_in=0x00000000, start pulse -> done in cycle 9, board_out=0x00000000, lines_cleared=0.
REQ-033 board_in=0x0000001F (row0=F, row1=1), start -> done in cycle 11, board_out=0x00000001, lines_cleared=1, score +1.
REQ-034 board_in=0xFFFFFFFF, start -> board_out=0x00000000, lines_cleared=8, done in cycle 25, score +8.
REQ-035 board_in=0x0F0F0F0F, start -> board_out=0x00000000, lines_cleared=4; repeat the job 3 more times -> score=32; preload score to 0xFFFA and run one more 4-line job -> score=0xFFFF.
REQ-036 start pulsed again in cycle 3 of a job -> ignored, exactly one done pulse; rst in cycle 4 -> done never asserts, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/line_clear_engine.sv
// line_clear_engine: collapses full rows of a COLS x ROWS board and counts them.
// Optional score accumulator when LINE_CLEAR_SCORE_EN is defined.
module line_clear_engine #(
    parameter int COLS = 4,
    parameter int ROWS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [COLS*ROWS-1:0]         board_in,
    output logic                         busy,
    output logic                         done,
    output logic [COLS*ROWS-1:0]         board_out,
    output logic [$clog2(ROWS+1)-1:0]    lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]                  score
`endif
);
    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + 1);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
    state_t          state, state_n;
    logic [N-1:0]    board, board_n, shifted;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idx, idx_n;
    logic            row_full, last;
    assign row_full = &board[idx*COLS +: COLS];
    assign last     = idx == IW'(ROWS - 1);
    // Rows at and above idx drop by one; the top row fills with zeros.
    always_comb begin
        shifted = board;
        for (int r = 0; r < ROWS - 1; r++)
            if (IW'(r) >= idx) shifted[r*COLS +: COLS] = board[(r+1)*COLS +: COLS];
        shifted[(ROWS-1)*COLS +: COLS] = '0;
    end
    always_comb begin
        state_n = state;
        board_n = board;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            IDLE: if (start) begin
                board_n = board_in;
                cnt_n   = '0;
                idx_n   = '0;
                state_n = SCAN;
            end
            SCAN: if (row_full) begin
                cnt_n   = cnt + CW'(1);
                state_n = SHIFT;
            end else if (!last) begin
                idx_n   = idx + IW'(1);
            end else begin
                state_n = DONE;
            end
            SHIFT: begin
                board_n = shifted;
                state_n = SCAN;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            board <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            board <= board_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign board_out     = board;
    assign lines_cleared = cnt;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q;
    logic [3:0]  pts;
    logic [16:0] sum;
    assign pts = cnt == CW'(0) ? 4'd0 : cnt == CW'(1) ? 4'd1 : cnt == CW'(2) ? 4'd3 :
                 cnt == CW'(3) ? 4'd5 : 4'd8;
    assign sum = {1'b0, score_q} + 17'(pts);
    // The count is final on the SCAN->DONE transition, so award there.
    always_ff @(posedge clk) begin
        if (rst) score_q <= '0;
        else if (state == SCAN && state_n == DONE) score_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end
    assign score = score_q;
`endif
endmodule
